// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of a shared FIFO write port.
// A winner is picked in IDLE and then holds the port for up to MAX_BURST
// beats. It stalls on i_full and gives the port up early when its request drops.
// Optional build macro FIFO_ARB_STATS_EN adds the o_beat_cnt per-requester
// accepted-beat counters. These saturate at 16'hFFFF and are cleared only by rstn.
module fifo_wr_arbiter #(
  parameter int DATA_W      = 128,
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 8,
  parameter int AF_THROTTLE = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic                      o_busy,
  output logic                      o_wren,
  output logic [DATA_W-1:0]         o_wrdata,
  input  logic                      i_full,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]     o_beat_cnt,
`endif
  input  logic                      i_alm_full
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   beat_q, beat_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int                 scan_idx;
  logic               owner_req;
  logic               wren;
  logic [NUM_REQ-1:0] ack;

  // Round-robin search: first requester after the previous owner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      scan_idx = (int'(last_q) + off) % NUM_REQ;
      if (!win_found && i_req[IDX_W'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(scan_idx);
      end
    end
  end

  assign owner_req = i_req[owner_q];

  // Next-state and write-side outputs; a grant costs one IDLE cycle with no write.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    wren    = 1'b0;
    ack     = '0;
    case (state_q)
      IDLE: begin
        if (win_found && !i_full && !((AF_THROTTLE != 0) && i_alm_full)) begin
          state_d = BURST;
          gnt_d   = NUM_REQ'(1) << win_idx;
          owner_d = win_idx;
          beat_d  = '0;
        end
      end
      BURST: begin
        // Almost-full is deliberately ignored here; only a full FIFO stalls a burst.
        wren         = owner_req && !i_full;
        ack[owner_q] = wren;
        if (wren) begin
          beat_d = beat_q + CNT_W'(1);
        end
        if ((wren && (beat_q == CNT_W'(MAX_BURST - 1))) || !owner_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = owner_q;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State register; reset makes requester 0 the first winner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign o_wren   = wren;
  assign o_ack    = ack;
  assign o_gnt    = gnt_q;
  assign o_busy   = (state_q == BURST);
  assign o_wrdata = (state_q == BURST) ? i_data[int'(owner_q)*DATA_W +: DATA_W] : '0;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_cnt_q [NUM_REQ];
  logic [15:0] stat_cnt_d [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    assign stat_cnt_d[gi] = (o_ack[gi] && (stat_cnt_q[gi] != 16'hFFFF))
                          ? stat_cnt_q[gi] + 16'd1 : stat_cnt_q[gi];

    // Saturating count of beats accepted from requester gi.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        stat_cnt_q[gi] <= '0;
      end else begin
        stat_cnt_q[gi] <= stat_cnt_d[gi];
      end
    end

    assign o_beat_cnt[gi*16 +: 16] = stat_cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter. Expected beats go into a scoreboard queue
// as each stimulus is issued. A monitor compares every FIFO write against it.
module tb_fifo_wr_arbiter;
  localparam int DATA_W  = 128;
  localparam int NUM_REQ = 4;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*DATA_W-1:0] i_data;
  logic [NUM_REQ-1:0]        o_ack;
  logic [NUM_REQ-1:0]        o_gnt;
  logic                      o_busy;
  logic                      o_wren;
  logic [DATA_W-1:0]         o_wrdata;
  logic                      i_full;
  logic                      i_alm_full;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     o_beat_cnt;
`endif

  fifo_wr_arbiter #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ), .MAX_BURST(8), .AF_THROTTLE(1)) dut (
    .clk(clk), .rstn(rstn), .i_req(i_req), .i_data(i_data), .o_ack(o_ack),
    .o_gnt(o_gnt), .o_busy(o_busy), .o_wren(o_wren), .o_wrdata(o_wrdata),
    .i_full(i_full),
`ifdef FIFO_ARB_STATS_EN
    .o_beat_cnt(o_beat_cnt),
`endif
    .i_alm_full(i_alm_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                req;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   seq     [NUM_REQ];
  int   exp_seq [NUM_REQ];
  int   ack_cnt [NUM_REQ];
  int   wr_cnt  = 0;

  function automatic logic [DATA_W-1:0] mkdata(input int k, input int s);
    logic [DATA_W-1:0] d;
    d = '0;
    d[15:0]             = s[15:0];
    d[39:32]            = k[7:0];
    d[DATA_W-1 -: 8]    = 8'hA0 + k[7:0];
    return d;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_data();
    for (int k = 0; k < NUM_REQ; k++) i_data[k*DATA_W +: DATA_W] = mkdata(k, seq[k]);
  endtask

  task automatic push_exp(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.req  = k;
      e.data = mkdata(k, exp_seq[k]);
      exp_seq[k]++;
      exp_q.push_back(e);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then advance producer data after the edge.
  task automatic tick();
    logic [NUM_REQ-1:0] ack_cap;
    @(negedge clk);
    ack_cap = o_ack;
    if (o_wren) wr_cnt++;
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ack_cap[k]) begin
        seq[k]++;
        ack_cnt[k]++;
      end
    end
    drive_data();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  // Monitor: every write must match the next scoreboard entry; no ack without a write.
  initial begin
    forever begin
      @(negedge clk);
      if (o_wren) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_write actual_data=%0h required=none", o_wrdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_wrdata", o_wrdata, e.data);
          chk("sb_ack", o_ack, NUM_REQ'(1) << e.req);
        end
      end else begin
        chk("ack_without_write", o_ack, '0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    for (int k = 0; k < NUM_REQ; k++) begin
      seq[k] = 0; exp_seq[k] = 0; ack_cnt[k] = 0;
    end
    rstn = 1'b0; i_req = '0; i_full = 1'b0; i_alm_full = 1'b0;
    drive_data();
    repeat (2) tick();
    chk("rst_gnt", o_gnt, '0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_wren", o_wren, 1'b0);
    chk("rst_ack", o_ack, '0);
`ifdef FIFO_ARB_STATS_EN
    chk("rst_stats", o_beat_cnt, '0);
`endif
    rstn = 1'b1;

    // Test 1: single requester, two back-to-back bursts with one bubble between.
    i_req = 4'b0001; push_exp(0, 16); wr_cnt = 0;
    tick();
    chk("t1_gnt", o_gnt, 4'b0001);
    chk("t1_busy", o_busy, 1'b1);
    chk("t1_wren", o_wren, 1'b1);
    repeat (8) tick();
    chk("t1_bubble_gnt", o_gnt, 4'b0000);
    chk("t1_bubble_busy", o_busy, 1'b0);
    tick();
    chk("t1_regrant", o_gnt, 4'b0001);
    repeat (8) tick();
    i_req = '0;
    chk("t1_writes_in_18", wr_cnt, 16);
    repeat (2) tick();
    chk("t1_sb_drained", exp_q.size(), 0);
`ifdef FIFO_ARB_STATS_EN
    chk("t1_stats_req0", o_beat_cnt[15:0], 16'd16);
`endif

    // Test 2: all requesting, rotation 0,1,2,3,0 with 8 acks each.
    do_reset();
    i_req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      int k;
      k = b % NUM_REQ;
      push_exp(k, 8);
      ack_cnt[k] = 0;
      tick();
      chk("t2_gnt", o_gnt, NUM_REQ'(1) << k);
      repeat (8) tick();
      chk("t2_acks", ack_cnt[k], 8);
    end
    i_req = '0;
    tick();
    chk("t2_sb_drained", exp_q.size(), 0);

    // Test 3: full stall mid-burst for requester 1.
    i_req = 4'b0010; push_exp(1, 8); wr_cnt = 0;
    tick();
    chk("t3_gnt", o_gnt, 4'b0010);
    repeat (3) tick();
    i_full = 1'b1; w0 = wr_cnt;
    repeat (5) tick();
    chk("t3_stall_writes", wr_cnt - w0, 0);
    chk("t3_gnt_held", o_gnt, 4'b0010);
    i_full = 1'b0;
    repeat (5) tick();
    i_req = '0;
    chk("t3_done_gnt", o_gnt, 4'b0000);
    chk("t3_total_writes", wr_cnt, 8);
    tick();

    // Test 4: almost-full holds off a new grant.
    i_alm_full = 1'b1; i_req = 4'b0100;
    repeat (4) tick();
    chk("t4_no_gnt", o_gnt, 4'b0000);
    chk("t4_not_busy", o_busy, 1'b0);
    i_alm_full = 1'b0; push_exp(2, 3);
    tick();
    chk("t4_gnt", o_gnt, 4'b0100);

    // Test 5: owner 2 releases after 3 beats; req3 wins over req0.
    i_req = 4'b1101;
    repeat (3) tick();
    i_req = 4'b1001; w0 = wr_cnt;
    tick();
    chk("t5_release_gnt", o_gnt, 4'b0000);
    chk("t5_release_nowrite", wr_cnt - w0, 0);
    push_exp(3, 8);
    tick();
    chk("t5_next_owner", o_gnt, 4'b1000);
    i_alm_full = 1'b1;  // ignored during a burst
    repeat (8) tick();
    chk("t5_burst_done", o_gnt, 4'b0000);
    i_alm_full = 1'b0; push_exp(0, 4);
    tick();
    chk("t5_then_req0", o_gnt, 4'b0001);

    // Test 6: reset mid-burst after 4 beats.
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    chk("t6_rst_gnt", o_gnt, 4'b0000);
    chk("t6_rst_wren", o_wren, 1'b0);
    chk("t6_rst_busy", o_busy, 1'b0);
`ifdef FIFO_ARB_STATS_EN
    chk("t6_rst_stats", o_beat_cnt, '0);
`endif
    tick();
    rstn = 1'b1;
    chk("t6_sb_partial", exp_q.size(), 0);
    push_exp(0, 8);
    tick();
    chk("t6_first_req0", o_gnt, 4'b0001);
    repeat (8) tick();
    i_req = '0;
`ifdef FIFO_ARB_STATS_EN
    chk("t6_stats_req0", o_beat_cnt[15:0], 16'd8);
    chk("t6_stats_req3", o_beat_cnt[63:48], 16'd0);
`endif
    repeat (2) tick();
    chk("t6_sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
